// File: rtl/char_dot_fetch_if.sv
// char_dot_fetch_if: request, ROM and pixel signals of the character dot fetcher
interface char_dot_fetch_if;
   logic        pix_ce;
   logic        char_req;
   logic [7:0]  char_code;
   logic [3:0]  char_ra;
   logic        char_set;
   logic        char_rev;
   logic        char_cur;
   logic        char_de;
   logic [12:0] dotA;
   logic [7:0]  dotD;
   logic        pix;
   logic        pix_de;
   logic        busy;
   logic        ovr;
   logic        unr;
   modport master (
      output pix_ce, char_req, char_code, char_ra, char_set, char_rev, char_cur, char_de, dotD,
      input  dotA, pix, pix_de, busy, ovr, unr
   );
   modport slave (
      input  pix_ce, char_req, char_code, char_ra, char_set, char_rev, char_cur, char_de, dotD,
      output dotA, pix, pix_de, busy, ovr, unr
   );
endinterface

// File: rtl/char_dot_fetch.sv
// char_dot_fetch: character ROM fetch, double-buffered dot byte and MSB-first pixel serialiser
module char_dot_fetch #(
   parameter int ROM_LAT = 1
) (
   input logic             clk_sys,
   input logic             reset,
   char_dot_fetch_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, CAPT} state_t;
   localparam logic [1:0] LAT_M1 = 2'(ROM_LAT - 1);
   state_t      state, stateNext;
   logic [1:0]  waitCnt, waitNext;
   logic        accept, load;
   logic [12:0] dotAddr;
   logic [2:0]  pendAttr, holdAttr;
   logic [7:0]  hold, shiftReg;
   logic        holdValid, revQ, curQ, deQ, ovrQ, unrQ;
   logic [2:0]  bitCnt;
   assign accept = bus.char_req && state == IDLE && !holdValid;
   assign load   = bus.pix_ce && bitCnt == 3'd7;
   // fetch FSM state and ROM wait counter
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         waitCnt <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitNext;
      end
   end
   // next state: accept a request, wait out the ROM latency, then capture
   always_comb begin
      stateNext = state;
      waitNext  = waitCnt;
      case (state)
         IDLE: if (accept) begin
            stateNext = WAIT;
            waitNext  = LAT_M1;
         end
         WAIT: if (waitCnt == 2'd0) stateNext = CAPT;
               else waitNext = waitCnt - 2'd1;
         CAPT: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end
   // ROM address, pending/hold buffers and dropped-request flag
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dotAddr   <= '0;
         pendAttr  <= '0;
         hold      <= '0;
         holdAttr  <= '0;
         holdValid <= 1'b0;
         ovrQ      <= 1'b0;
      end else begin
         ovrQ <= bus.char_req && !accept;
         if (accept) begin
            dotAddr  <= {bus.char_set, bus.char_code, bus.char_ra};
            pendAttr <= {bus.char_rev, bus.char_cur, bus.char_de};
         end
         if (state == CAPT) begin
            hold      <= bus.dotD;
            holdAttr  <= pendAttr;
            holdValid <= 1'b1;
         end else if (load) holdValid <= 1'b0;
      end
   end
   // pixel shifter: reload from the hold buffer every 8 pixels, blank on underrun
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         shiftReg          <= '0;
         bitCnt            <= 3'd7;
         {revQ, curQ, deQ} <= '0;
         unrQ              <= 1'b0;
      end else begin
         unrQ <= load && !holdValid;
         if (load) begin
            bitCnt            <= 3'd0;
            shiftReg          <= holdValid ? hold : 8'h00;
            {revQ, curQ, deQ} <= holdValid ? holdAttr : 3'b000;
         end else if (bus.pix_ce) begin
            shiftReg <= {shiftReg[6:0], 1'b0};
            bitCnt   <= bitCnt + 3'd1;
         end
      end
   end
   assign bus.dotA   = dotAddr;
   assign bus.busy   = state != IDLE;
   assign bus.ovr    = ovrQ;
   assign bus.unr    = unrQ;
   assign bus.pix    = (shiftReg[7] ^ revQ ^ curQ) & deQ;
   assign bus.pix_de = deQ;
endmodule
